// File: rtl/anti_park.sv
// Inverse Park transform: (d, q) rotated by theta into stationary-frame (alpha, beta).
// Latency: 3 clocks (ROM/input register, product register, sum/saturate register).
// Backpressure: none; a new sample is accepted every clock and outputs are always live.
module anti_park (
    input  logic               clock,
    input  logic               reset,
    input  logic        [15:0] theta,
    input  logic signed [17:0] d,
    input  logic signed [17:0] q,
    output logic signed [17:0] alpha,
    output logic signed [17:0] beta
);

    // pi in unsigned Q2.60 fixed point, used only to build the sine table.
    localparam logic [63:0] PI_Q60 = 64'h3243_F6A8_885A_308D;

    // round(65536 * sin(idx * pi / 512)) via a fixed-point Taylor series;
    // evaluated only at elaboration to fill the quarter-wave table.
    function automatic logic [16:0] sin_q16(input int idx);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] acc;
        x    = (128'(PI_Q60) * 128'(idx)) >> 9;
        x2   = (x * x) >> 60;
        term = x;
        acc  = x;
        for (int n = 1; n <= 12; n++) begin
            term = (term * x2) >> 60;
            term = term / 128'((2 * n) * (2 * n + 1));
            if (n % 2 == 1) acc = acc - term;
            else            acc = acc + term;
        end
        return 17'((acc + (128'(1) << 43)) >> 44);
    endfunction

    // Clamp a post-shift sum into the 18-bit signed output range.
    function automatic logic [17:0] sat18(input logic signed [20:0] v);
        if (v > 21'sd131071)       return 18'h1FFFF;
        else if (v < -21'sd131072) return 18'h20000;
        else                       return v[17:0];
    endfunction

    // Quarter-wave table, 257 entries so that both 0 and 1.0 (= 2^16) are exact.
    logic [16:0] rom [0:256];
    for (genvar g = 0; g <= 256; g++) begin : g_rom
        localparam logic [16:0] ENTRY = sin_q16(g);
        assign rom[g] = ENTRY;
    end

    // Angle decode: theta[5:0] is dropped, the table is addressed by theta[13:6].
    logic [7:0]         idx;
    logic [8:0]         idx_c;
    logic signed [17:0] t_i;
    logic signed [17:0] t_c;
    logic signed [17:0] sin_n;
    logic signed [17:0] cos_n;

    assign idx   = theta[13:6];
    assign idx_c = 9'd256 - {1'b0, idx};
    assign t_i   = {1'b0, rom[{1'b0, idx}]};
    assign t_c   = {1'b0, rom[idx_c]};

    // Fold the quarter-wave table out to the full circle by quadrant.
    always_comb begin
        sin_n = t_i;
        cos_n = t_c;
        case (theta[15:14])
            2'd0: begin sin_n =  t_i; cos_n =  t_c; end
            2'd1: begin sin_n =  t_c; cos_n = -t_i; end
            2'd2: begin sin_n = -t_i; cos_n = -t_c; end
            2'd3: begin sin_n = -t_c; cos_n =  t_i; end
            default: ;
        endcase
    end

    // Stage 1: capture d, q and the table lookup together so they stay aligned.
    logic signed [17:0] d_r, q_r, sin_r, cos_r;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_r   <= '0;
            q_r   <= '0;
            sin_r <= '0;
            cos_r <= '0;
        end else begin
            d_r   <= d;
            q_r   <= q;
            sin_r <= sin_n;
            cos_r <= cos_n;
        end
    end

    // Stage 2: the four full-precision 18x18 products.
    logic signed [35:0] p_dc, p_qs, p_ds, p_qc;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_dc <= '0;
            p_qs <= '0;
            p_ds <= '0;
            p_qc <= '0;
        end else begin
            p_dc <= d_r * cos_r;
            p_qs <= q_r * sin_r;
            p_ds <= d_r * sin_r;
            p_qc <= q_r * cos_r;
        end
    end

    // 37-bit sums cannot overflow; dropping the low 16 bits is a floor shift.
    logic [36:0] sum_a;
    logic [36:0] sum_b;
    logic        unused_lsbs;

    assign sum_a       = {p_dc[35], p_dc} - {p_qs[35], p_qs};
    assign sum_b       = {p_ds[35], p_ds} + {p_qc[35], p_qc};
    assign unused_lsbs = ^{theta[5:0], sum_a[15:0], sum_b[15:0]};

    // Stage 3: shift, saturate each output independently, register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alpha <= '0;
            beta  <= '0;
        end else begin
            alpha <= sat18(sum_a[36:16]);
            beta  <= sat18(sum_b[36:16]);
        end
    end

endmodule

// File: tb/tb_anti_park.sv
module tb_anti_park;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] theta = 16'h0000;
    logic [17:0] d     = 18'h0A000;
    logic [17:0] q     = 18'h05000;
    logic [17:0] alpha;
    logic [17:0] beta;

    anti_park dut (
        .clock (clock),
        .reset (reset),
        .theta (theta),
        .d     (d),
        .q     (q),
        .alpha (alpha),
        .beta  (beta)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [17:0] a;
        logic [17:0] b;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    // ---------------- reference model ----------------
    function automatic int rom_t(input int i);
        real v;
        v = 65536.0 * $sin(real'(i) * 3.14159265358979323846 / 512.0);
        return int'($floor(v + 0.5));
    endfunction

    // Sine over the full circle in 1024 steps, using the quantized table values.
    function automatic int sin_k(input int kin);
        int k;
        k = kin % 1024;
        if (k < 256)      return  rom_t(k);
        else if (k < 512) return  rom_t(512 - k);
        else if (k < 768) return -rom_t(k - 512);
        else              return -rom_t(1024 - k);
    endfunction

    function automatic logic [17:0] sat(input longint acc);
        longint v;
        v = acc >>> 16;
        if (v > 131071)       return 18'h1FFFF;
        else if (v < -131072) return 18'h20000;
        else                  return v[17:0];
    endfunction

    task automatic model(input logic [15:0] th, input logic [17:0] dd, input logic [17:0] qq,
                         output logic [17:0] ea, output logic [17:0] eb);
        int     k;
        longint s, c, dv, qv;
        k  = int'(th[15:6]);
        s  = longint'(sin_k(k));
        c  = longint'(sin_k(k + 256));
        dv = longint'($signed(dd));
        qv = longint'($signed(qq));
        ea = sat(dv * c - qv * s);
        eb = sat(dv * s + qv * c);
    endtask

    task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%05h expected 0x%05h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clock) begin
        exp_t e;
        #1;
        cyc = cyc + 1;
        if (reset) begin
            chk("rst_alpha", alpha, 18'h0);
            chk("rst_beta", beta, 18'h0);
        end else if (sb.size() > 0) begin
            if (sb[0].due < cyc) begin
                e = sb.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missed_output: due cyc %0d now %0d", e.due, cyc);
            end else if (sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("alpha", alpha, e.a);
                chk("beta", beta, e.b);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic put(input logic [15:0] th, input logic [17:0] dd, input logic [17:0] qq,
                       input logic [17:0] ea, input logic [17:0] eb);
        @(negedge clock);
        theta = th;
        d     = dd;
        q     = qq;
        sb.push_back('{ea, eb, cyc + 3});
    endtask

    task automatic put_m(input logic [15:0] th, input logic [17:0] dd, input logic [17:0] qq);
        logic [17:0] ea, eb;
        model(th, dd, qq, ea, eb);
        put(th, dd, qq, ea, eb);
    endtask

    // Release reset at a falling edge; the held inputs are the first sample.
    task automatic release_reset();
        logic [17:0] ea, eb;
        int          r;
        @(negedge clock);
        reset = 1'b0;
        r = cyc + 1;
        model(theta, d, q, ea, eb);
        sb.push_back('{18'h0, 18'h0, r});
        sb.push_back('{18'h0, 18'h0, r + 1});
        sb.push_back('{ea, eb, r + 2});
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("rst_async_alpha", alpha, 18'h0);
        chk("rst_async_beta", beta, 18'h0);
        release_reset();
    endtask

    task automatic stream4(input logic [17:0] dd, input logic [17:0] qq);
        put_m(16'h2000, dd, qq);
        put_m(16'h6000, dd, qq);
        put_m(16'hA000, dd, qq);
        put_m(16'hE000, dd, qq);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] th;
        logic [17:0] dd, qq;

        repeat (3) @(negedge clock);
        release_reset();

        // Cardinal angles and 45 degrees.
        put(16'h0000, 18'h0A000, 18'h05000, 18'h0A000, 18'h05000);
        put(16'h4000, 18'h0A000, 18'h05000, 18'h3B000, 18'h0A000);
        put(16'h8000, 18'h0A000, 18'h05000, 18'h36000, 18'h3B000);
        put(16'hC000, 18'h0A000, 18'h05000, 18'h05000, 18'h36000);
        put(16'h2000, 18'h0A000, 18'h05000, 18'h03891, 18'h0A9B4);

        // Saturation at the extremes.
        put(16'h2000, 18'h1FFFF, 18'h1FFFF, 18'h00000, 18'h1FFFF);
        put(16'h2000, 18'h20000, 18'h20000, 18'h00000, 18'h20000);

        // Streaming through the odd octants, reset mid-stream, refill.
        stream4(18'h0A000, 18'h05000);
        stream4(18'h31234, 18'h0ABCD);
        put_m(16'h2000, 18'h0A000, 18'h05000);
        put_m(16'h6000, 18'h0A000, 18'h05000);
        pulse_reset();
        stream4(18'h0A000, 18'h05000);
        stream4(18'h1FFFF, 18'h20000);

        // Angle wrap.
        put_m(16'hFFC0, 18'h0A000, 18'h05000);
        put_m(16'hFFFF, 18'h0A000, 18'h05000);
        put_m(16'h0000, 18'h0A000, 18'h05000);
        put_m(16'h003F, 18'h0A000, 18'h05000);

        // Random stream with occasional full-scale operands.
        for (int i = 0; i < 400; i++) begin
            th = 16'($urandom);
            dd = 18'($urandom);
            qq = 18'($urandom);
            if ($urandom_range(7) == 0) dd = ($urandom_range(1) == 0) ? 18'h1FFFF : 18'h20000;
            if ($urandom_range(7) == 0) qq = ($urandom_range(1) == 0) ? 18'h1FFFF : 18'h20000;
            put_m(th, dd, qq);
            if (i == 200) pulse_reset();
        end

        // Drain.
        for (int i = 0; i < 4; i++) put_m(16'h0000, 18'h0, 18'h0);
        repeat (3) @(negedge clock);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d outputs outstanding, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
